jpeg_byte_fetch: RTL and testbench
==================================

JPEG_BYTE_FETCH -- requirements
Module: jpeg_byte_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the ROM byte-address width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins a fetch from address 0.
REQ-005 SHALL have port rom_addr, output, ADDR_WIDTH bits: registered ROM read address.
REQ-006 SHALL have port rom_rd_en, output, 1 bit: high in every cycle the module samples rom_data.
REQ-007 SHALL have port rom_data, input, 8 bits: combinational ROM byte for the current rom_addr.
REQ-008 SHALL have port rom_done, input, 1 bit: high when rom_addr is the last ROM address.
REQ-009 SHALL have port out_data, output, 8 bits: the emitted byte, either entropy data or a marker code.
REQ-010 SHALL have port out_marker, output, 1 bit: qualifies out_data as a marker code (the byte following 0xFF).
REQ-011 SHALL have port out_valid / out_ready, output / input, 1 bit each: the downstream valid/ready handshake.
REQ-012 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-013 SHALL have port done / err, outputs, 1 bit each: done is a one-cycle completion pulse; err is a sticky error flag.
REQ-014 SHALL have port byte_cnt, output, ADDR_WIDTH+1 bits: count of handshaken output bytes.

Function
REQ-015 SHALL implement the states IDLE, FETCH, FF_SEEN, DRAIN.
REQ-016 In IDLE, start SHALL clear rom_addr, byte_cnt and err, set busy, and enter FETCH; start SHALL be ignored when not in IDLE.
REQ-017 Slot rule: a byte SHALL be loaded into the output register only when !out_valid || out_ready, and rom_rd_en SHALL be low otherwise.
REQ-018 FETCH, byte != 0xFF: emit the byte with out_marker=0 and increment rom_addr.
REQ-019 FETCH, byte == 0xFF: emit nothing, increment rom_addr, and enter FF_SEEN.
REQ-020 FF_SEEN, byte 0x00: emit 0xFF with out_marker=0 (stuffing removed), increment rom_addr, and return to FETCH.
REQ-021 FF_SEEN, byte 0xFF: treat as a fill byte, emit nothing, increment rom_addr, and stay in FF_SEEN.
REQ-022 FF_SEEN, any other byte: emit the byte with out_marker=1, increment rom_addr, and return to FETCH.
REQ-023 The marker emitted SHALL be 0xD9 (EOI); the module SHALL then enter DRAIN.
REQ-024 The first emitted item SHALL be marker 0xD8 (SOI); otherwise err SHALL be set and the module enters DRAIN after that item.
REQ-025 Throughput SHALL be one output byte per cycle while out_ready is held high; the latency from start to the first out_valid SHALL be 3 cycles for an FF D8 stream.
REQ-026 out_data and out_marker SHALL be held stable while out_valid && !out_ready.
REQ-027 Sampling a byte with rom_done=1 without reaching EOI SHALL process that byte, set err, and enter DRAIN; rom_addr SHALL NOT wrap.
REQ-028 A trailing 0xFF at the last address SHALL set err and not be emitted.
REQ-029 DRAIN: once out_valid is 0 (the last byte has been handshaken), pulse done for 1 cycle, clear busy, and enter IDLE.
REQ-030 byte_cnt SHALL increment on each out_valid && out_ready handshake, markers included.

Reset
REQ-031 While rst=0, SHALL force state IDLE; rom_addr, out_data, byte_cnt = 0; out_valid, out_marker, busy, done, err, rom_rd_en = 0.
REQ-032 Reset asserted mid-stream SHALL abort the stream with no done pulse, and any pending output SHALL be dropped.

Structure
REQ-033 The shared package jpeg_pkg SHALL hold the constants JPEG_FF=8'hFF, JPEG_SOI=8'hD8, JPEG_EOI=8'hD9, JPEG_STUFF=8'h00, and the fetch state enum.
REQ-034 SHALL be a single module with no sub-module; the output register and the handshake SHALL be inline.

Verification
REQ-035 ROM FF D8 12 FF 00 34 FF D9, out_ready=1 -> emitted D8(m), 12, FF, 34, D9(m); byte_cnt=5; done pulse; err=0.
REQ-036 Same ROM, out_ready toggling 1/0 each cycle -> identical sequence, out_data stable while stalled, no byte lost or duplicated.
REQ-037 ROM FF D8 FF FF FF C4 FF D9 -> emitted D8(m), C4(m), D9(m); fill bytes dropped; byte_cnt=3.
REQ-038 ROM starting 12 34 -> byte 12 emitted, err=1, done pulse, busy=0.
REQ-039 ADDR_WIDTH=4, 16-byte ROM FF D8 then 0x11 x14 with no EOI -> 15 bytes emitted, err=1 on rom_done, rom_addr stays 15.
REQ-040 rst=0 asserted mid-stream -> all outputs 0 immediately; new start restarts from address 0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// ============================================================================
// Module : jpeg_pkg
// Brief  : Shared JPEG marker constants and byte-fetch state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpeg_pkg;

    localparam logic [7:0] JPEG_FF    = 8'hFF;
    localparam logic [7:0] JPEG_SOI   = 8'hD8;
    localparam logic [7:0] JPEG_EOI   = 8'hD9;
    localparam logic [7:0] JPEG_STUFF = 8'h00;

    localparam logic [1:0] FS_IDLE    = 2'd0;
    localparam logic [1:0] FS_FETCH   = 2'd1;
    localparam logic [1:0] FS_FF_SEEN = 2'd2;
    localparam logic [1:0] FS_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = FS_IDLE,
        ST_FETCH   = FS_FETCH,
        ST_FF_SEEN = FS_FF_SEEN,
        ST_DRAIN   = FS_DRAIN
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/jpeg_byte_fetch.sv
// ============================================================================
// Module : jpeg_byte_fetch
// Brief  : Walks a JPEG ROM from address 0, removes byte stuffing and fill
//          bytes, and streams data bytes and marker codes downstream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpeg_byte_fetch
    import jpeg_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rd_en,
    input  logic [7:0]            rom_data,
    input  logic                  rom_done,
    output logic [7:0]            out_data,
    output logic                  out_marker,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   byte_cnt
);

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [7:0]            r_out_data;
    logic                  r_out_marker;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_first;
    logic [ADDR_WIDTH:0]   r_byte_cnt;

    logic                  w_slot;
    logic                  w_sample;
    logic                  w_emit;
    logic [7:0]            w_emit_data;
    logic                  w_emit_marker;
    logic                  w_bad_first;
    logic                  w_eoi;
    logic                  w_err_set;
    fetch_state_e          w_state_nxt;

    // A ROM byte is only consumed when the output register can accept it,
    // so a stalled downstream also stalls the address walk.
    assign w_slot   = !r_out_valid || out_ready;
    assign w_sample = ((r_state == ST_FETCH) || (r_state == ST_FF_SEEN)) && w_slot;

    always_comb begin
        w_emit        = 1'b0;
        w_emit_data   = rom_data;
        w_emit_marker = 1'b0;
        if (r_state == ST_FETCH) begin
            w_emit = (rom_data != JPEG_FF);
        end else if (r_state == ST_FF_SEEN) begin
            if (rom_data == JPEG_STUFF) begin
                w_emit      = 1'b1;
                w_emit_data = JPEG_FF;
            end else if (rom_data != JPEG_FF) begin
                w_emit        = 1'b1;
                w_emit_marker = 1'b1;
            end
        end
    end

    assign w_bad_first = r_first && !(w_emit_marker && (w_emit_data == JPEG_SOI));
    assign w_eoi       = w_emit_marker && (w_emit_data == JPEG_EOI);

    // Priority: a bad leading item ends the stream even if it is EOI; EOI on
    // the last address is a clean finish, anything else at the end is an error.
    always_comb begin
        w_err_set   = 1'b0;
        w_state_nxt = r_state;
        if (w_emit && w_bad_first) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_DRAIN;
        end else if (w_emit && w_eoi) begin
            w_state_nxt = ST_DRAIN;
        end else if (rom_done) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_DRAIN;
        end else if (rom_data == JPEG_FF) begin
            w_state_nxt = ST_FF_SEEN;
        end else begin
            w_state_nxt = ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_rom_addr   <= '0;
            r_out_data   <= '0;
            r_out_marker <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_first      <= 1'b0;
            r_byte_cnt   <= '0;
        end else begin
            r_done <= 1'b0;

            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_byte_cnt  <= r_byte_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rom_addr <= '0;
                        r_byte_cnt <= '0;
                        r_err      <= 1'b0;
                        r_first    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH, ST_FF_SEEN: begin
                    if (w_sample) begin
                        if (!rom_done) begin
                            r_rom_addr <= r_rom_addr + 1'b1;
                        end
                        if (w_emit) begin
                            r_out_data   <= w_emit_data;
                            r_out_marker <= w_emit_marker;
                            r_out_valid  <= 1'b1;
                            r_first      <= 1'b0;
                        end
                        if (w_err_set) begin
                            r_err <= 1'b1;
                        end
                        r_state <= w_state_nxt;
                    end
                end
                ST_DRAIN: begin
                    if (!r_out_valid) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = r_rom_addr;
    assign rom_rd_en  = w_sample;
    assign out_data   = r_out_data;
    assign out_marker = r_out_marker;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign byte_cnt   = r_byte_cnt;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_byte_fetch.sv
// ============================================================================
// Module : tb_jpeg_byte_fetch
// Brief  : Self-checking bench for jpeg_byte_fetch against a ROM-parsing model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jpeg_byte_fetch;
    import jpeg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        ready = 1'b1;
    logic        start_a, start_b;

    logic [15:0] addr_a;
    logic        rd_a, mk_a, v_a, busy_a, done_a, err_a;
    logic [7:0]  rdata_a, data_a;
    logic        rdone_a;
    logic [16:0] cnt_a;

    logic [3:0]  addr_b;
    logic        rd_b, mk_b, v_b, busy_b, done_b, err_b;
    logic [7:0]  rdata_b, data_b;
    logic        rdone_b;
    logic [4:0]  cnt_b;

    logic [7:0]  rom_mem [0:255];
    int          rom_len = 1;

    logic        m_valid, m_marker, m_busy, m_done, m_err, m_rd;
    logic [7:0]  m_data;
    logic [31:0] m_cnt;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       exp_err;

    always #5 clk = ~clk;

    always_comb begin
        start_a  = start & ~sel;
        start_b  = start & sel;
        rdata_a  = (int'(addr_a) < rom_len) ? rom_mem[addr_a[7:0]] : 8'h00;
        rdone_a  = (int'(addr_a) == rom_len - 1);
        rdata_b  = (int'(addr_b) < rom_len) ? rom_mem[{4'd0, addr_b}] : 8'h00;
        rdone_b  = (int'(addr_b) == rom_len - 1);
        m_valid  = sel ? v_b    : v_a;
        m_marker = sel ? mk_b   : mk_a;
        m_data   = sel ? data_b : data_a;
        m_busy   = sel ? busy_b : busy_a;
        m_done   = sel ? done_b : done_a;
        m_err    = sel ? err_b  : err_a;
        m_rd     = sel ? rd_b   : rd_a;
        m_cnt    = sel ? {27'd0, cnt_b} : {15'd0, cnt_a};
    end

    jpeg_byte_fetch #(.ADDR_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .rom_addr(addr_a), .rom_rd_en(rd_a), .rom_data(rdata_a), .rom_done(rdone_a),
        .out_data(data_a), .out_marker(mk_a), .out_valid(v_a), .out_ready(ready),
        .busy(busy_a), .done(done_a), .err(err_a), .byte_cnt(cnt_a)
    );

    jpeg_byte_fetch #(.ADDR_WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .rom_addr(addr_b), .rom_rd_en(rd_b), .rom_data(rdata_b), .rom_done(rdone_b),
        .out_data(data_b), .out_marker(mk_b), .out_valid(v_b), .out_ready(ready),
        .busy(busy_b), .done(done_b), .err(err_b), .byte_cnt(cnt_b)
    );

    // Reference: parse the ROM image as a JPEG byte stream, item by item.
    task automatic build_expected();
        int         i;
        logic [7:0] b;
        logic       last, m, stop, first;
        exp_q.delete();
        exp_err = 1'b0;
        i = 0; first = 1'b1; stop = 1'b0;
        while (!stop) begin
            b = rom_mem[i]; last = (i == rom_len - 1); m = 1'b0;
            if (b == JPEG_FF) begin
                if (last) begin
                    exp_err = 1'b1; stop = 1'b1;
                end else begin
                    i++;
                    while (rom_mem[i] == JPEG_FF && i != rom_len - 1) i++;
                    b = rom_mem[i]; last = (i == rom_len - 1);
                    if (b == JPEG_FF) begin
                        exp_err = 1'b1; stop = 1'b1;
                    end else if (b == JPEG_STUFF) begin
                        b = JPEG_FF;
                    end else begin
                        m = 1'b1;
                    end
                end
            end
            if (!stop) begin
                exp_q.push_back({m, b});
                if (first && !(m && b == JPEG_SOI)) begin
                    exp_err = 1'b1; stop = 1'b1;
                end else if (m && b == JPEG_EOI) begin
                    stop = 1'b1;
                end else if (last) begin
                    exp_err = 1'b1; stop = 1'b1;
                end
                first = 1'b0;
                i++;
            end
        end
    endtask

    task automatic load_rom(input logic [7:0] img [$]);
        rom_len = img.size();
        for (int k = 0; k < 256; k++) rom_mem[k] = (k < img.size()) ? img[k] : 8'h00;
    endtask

    // mode 0: ready always high, 1: toggles each cycle, 2: random
    task automatic run_stream(input string name, input int mode, input int exp_lat);
        int         cyc, dones, lat, stab_bad, rd_bad, extra_hs;
        logic       pv, pr, seen_done, busy_seen;
        logic [8:0] pd;
        build_expected();
        got_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0; lat = -1; dones = 0; stab_bad = 0; rd_bad = 0; extra_hs = 0;
        pv = 1'b0; pr = 1'b1; pd = '0; seen_done = 1'b0; busy_seen = 1'b0;
        while (!seen_done && cyc < 3000) begin
            cyc++;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2 == 1);
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (cyc == 1) busy_seen = m_busy;
            if (m_valid && lat < 0) lat = cyc;
            if (pv && !pr && !(m_valid && {m_marker, m_data} == pd)) stab_bad++;
            if (m_rd && m_valid && !ready) rd_bad++;
            if (m_valid && ready) got_q.push_back({m_marker, m_data});
            if (m_done) begin dones++; seen_done = 1'b1; end
            pv = m_valid; pr = ready; pd = {m_marker, m_data};
            if (!seen_done) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (m_done) dones++;
            if (m_valid) extra_hs++;
        end
        ready = 1'b1;

        tests++;
        if (!seen_done) begin fails++; $display("FAIL %s timeout: no done within %0d cycles", name, cyc); end
        tests++;
        if (busy_seen !== 1'b1) begin fails++; $display("FAIL %s busy_after_start got %b want 1", name, busy_seen); end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL %s item_count got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            tests++;
            if (got_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL %s item[%0d] got m%b/%h want m%b/%h", name, k,
                                  got_q[k][8], got_q[k][7:0], exp_q[k][8], exp_q[k][7:0]);
            end
        end
        tests++;
        if (m_cnt !== 32'(exp_q.size())) begin fails++; $display("FAIL %s byte_cnt got %0d want %0d", name, m_cnt, exp_q.size()); end
        tests++;
        if (m_err !== exp_err) begin fails++; $display("FAIL %s err got %b want %b", name, m_err, exp_err); end
        tests++;
        if (dones != 1) begin fails++; $display("FAIL %s done_pulses got %0d want 1", name, dones); end
        tests++;
        if (m_busy !== 1'b0) begin fails++; $display("FAIL %s busy_end got %b want 0", name, m_busy); end
        tests++;
        if (stab_bad != 0 || extra_hs != 0) begin
            fails++; $display("FAIL %s stall_stability got %0d unstable/%0d late-valid want 0/0", name, stab_bad, extra_hs);
        end
        tests++;
        if (rd_bad != 0) begin fails++; $display("FAIL %s rd_en_when_blocked got %0d want 0", name, rd_bad); end
        if (exp_lat > 0) begin
            tests++;
            if (lat != exp_lat) begin fails++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        end
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({addr_a, rd_a, data_a, mk_a, v_a, busy_a, done_a, err_a, cnt_a} !== '0) begin
            fails++; $display("FAIL %s outputs_a got %h want 0", name,
                              {addr_a, rd_a, data_a, mk_a, v_a, busy_a, done_a, err_a, cnt_a});
        end
        tests++;
        if ({addr_b, rd_b, data_b, mk_b, v_b, busy_b, done_b, err_b, cnt_b} !== '0) begin
            fails++; $display("FAIL %s outputs_b got %h want 0", name,
                              {addr_b, rd_b, data_b, mk_b, v_b, busy_b, done_b, err_b, cnt_b});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] img [$] = '{8'hFF, 8'hD8, 8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'hD9};
        logic [8:0] want [$] = '{9'h1D8, 9'h012, 9'h0FF, 9'h034, 9'h1D9};
        sel = 1'b0;
        load_rom(img);
        run_stream("basic", 0, 3);
        tests++;
        if (got_q != want) begin
            fails++; $display("FAIL basic_literal got %0d items (first %h) want 5 items D8m 12 FF 34 D9m",
                              got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h000);
        end
        tests++;
        if (m_cnt !== 32'd5) begin fails++; $display("FAIL basic_cnt_literal got %0d want 5", m_cnt); end
    endtask

    task automatic test_stall();
        logic [7:0] img [$] = '{8'hFF, 8'hD8, 8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'hD9};
        sel = 1'b0;
        load_rom(img);
        run_stream("stall_toggle", 1, 0);
    endtask

    task automatic test_fill();
        logic [7:0] img [$] = '{8'hFF, 8'hD8, 8'hFF, 8'hFF, 8'hFF, 8'hC4, 8'hFF, 8'hD9};
        sel = 1'b0;
        load_rom(img);
        run_stream("fill_bytes", 0, 0);
        tests++;
        if (m_cnt !== 32'd3) begin fails++; $display("FAIL fill_cnt_literal got %0d want 3", m_cnt); end
    endtask

    task automatic test_no_soi();
        logic [7:0] img [$] = '{8'h12, 8'h34, 8'h56, 8'h78};
        sel = 1'b0;
        load_rom(img);
        run_stream("no_soi", 2, 0);
        tests++;
        if (m_err !== 1'b1) begin fails++; $display("FAIL no_soi_err_literal got %b want 1", m_err); end
    endtask

    task automatic test_rom_end();
        logic [7:0] img [$];
        img.push_back(8'hFF); img.push_back(8'hD8);
        for (int k = 0; k < 14; k++) img.push_back(8'h11);
        sel = 1'b1;
        load_rom(img);
        run_stream("rom_end_aw4", 0, 0);
        tests++;
        if (addr_b !== 4'd15) begin fails++; $display("FAIL rom_end_addr got %0d want 15", addr_b); end
        tests++;
        if (m_cnt !== 32'd15) begin fails++; $display("FAIL rom_end_cnt got %0d want 15", m_cnt); end
        sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [7:0] img [$] = '{8'hFF, 8'hD8, 8'h21, 8'h22, 8'h23, 8'hFF, 8'hD9};
        int done_seen;
        sel = 1'b0;
        load_rom(img);
        @(negedge clk); ready = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (v_a !== 1'b1) begin fails++; $display("FAIL mid_reset_pre_valid got %b want 1", v_a); end
        #2 rst = 1'b0;
        #1 check_all_zero("mid_reset");
        done_seen = 0;
        repeat (3) begin @(negedge clk); if (done_a) done_seen++; end
        rst = 1'b1; ready = 1'b1;
        repeat (3) begin @(negedge clk); if (done_a) done_seen++; end
        tests++;
        if (done_seen != 0) begin fails++; $display("FAIL mid_reset_no_done got %0d want 0", done_seen); end
        run_stream("after_reset", 2, 0);
    endtask

    task automatic test_random();
        logic [7:0] img [$];
        int len, r;
        sel = 1'b0;
        for (int t = 0; t < 10; t++) begin
            img.delete();
            len = $urandom_range(4, 48);
            img.push_back(8'hFF);
            img.push_back(($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hD8);
            for (int k = 2; k < len; k++) begin
                r = $urandom_range(0, 9);
                if (r < 3)       img.push_back(8'hFF);
                else if (r == 3) img.push_back(8'h00);
                else             img.push_back(8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                img[len-2] = 8'hFF;
                img[len-1] = 8'hD9;
            end
            load_rom(img);
            run_stream($sformatf("random%0d", t), 2, 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) rom_mem[k] = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_fill();
        test_no_soi();
        test_rom_end();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
